// File: rtl/hazard_ctrl_p.sv
// Pipeline hazard controller: load-use / RAW stalls, branch flush, memory-busy
// freeze and a halt drain sequence, plus a saturating stalled-cycle counter.
module hazard_ctrl_p #(
  parameter int unsigned REG_W     = 3,
  parameter int unsigned NUM_SRC   = 2,
  parameter int unsigned PCSRC_W   = 3,
  parameter int unsigned LOAD_LAT  = 1,
  parameter int unsigned FWD       = 1,
  parameter int unsigned DRAIN_CYC = 3,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PCSRC_W-1:0]         pc_src,
  input  logic                       halt_req,
  input  logic [NUM_SRC*REG_W-1:0]   id_src,
  input  logic [NUM_SRC-1:0]         id_src_vld,
  input  logic                       ex_mem_read,
  input  logic                       ex_reg_write,
  input  logic [REG_W-1:0]           ex_rd,
  input  logic                       mem_reg_write,
  input  logic                       wb_reg_write,
  input  logic [REG_W-1:0]           mem_rd,
  input  logic [REG_W-1:0]           wb_rd,
  input  logic                       mem_busy,
  output logic                       pc_stall,
  output logic                       fd_stall,
  output logic                       de_stall,
  output logic                       em_stall,
  output logic                       fd_nop,
  output logic                       de_nop,
  output logic                       mw_nop,
  output logic                       halt_done,
  output logic [CNT_W-1:0]           stall_cnt
);

  localparam int unsigned LUC_W = $clog2(LOAD_LAT + 1);
  localparam int unsigned DC_W  = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [LUC_W-1:0] LUC_LOAD = LUC_W'(LOAD_LAT - 1);
  localparam logic [DC_W-1:0]  DC_LOAD  = DC_W'(DRAIN_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [LUC_W-1:0] luc_q, luc_d;
  logic [DC_W-1:0]  dc_q, dc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             halt_done_q, halt_done_d;

  logic match_ex_s, match_mem_s, match_wb_s;
  logic lu_hit_s, raw_hit_s, dstall_s, br_taken_s;
  logic unused_pc_src0_s;

  // Register x0 is hard-wired zero, so a zero destination never creates a dependency.
  function automatic logic src_match(input logic [NUM_SRC*REG_W-1:0] srcs,
                                     input logic [NUM_SRC-1:0]       vld,
                                     input logic [REG_W-1:0]         rd);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      hit = hit | (vld[i] & (srcs[i*REG_W +: REG_W] == rd) & (rd != '0));
    end
    return hit;
  endfunction

  assign unused_pc_src0_s = pc_src[0];

  always_comb begin
    match_ex_s  = src_match(id_src, id_src_vld, ex_rd);
    match_mem_s = src_match(id_src, id_src_vld, mem_rd);
    match_wb_s  = src_match(id_src, id_src_vld, wb_rd);
    lu_hit_s    = ex_mem_read & ex_reg_write & match_ex_s;
    if (FWD != 0) begin
      raw_hit_s = 1'b0;
    end else begin
      raw_hit_s = (ex_reg_write & match_ex_s) | (mem_reg_write & match_mem_s) |
                  (wb_reg_write & match_wb_s);
    end
    dstall_s   = lu_hit_s | (luc_q != '0) | raw_hit_s;
    br_taken_s = |pc_src[PCSRC_W-1:1];
  end

  // The hit cycle itself is the first stall cycle, so only LOAD_LAT-1 more are counted.
  always_comb begin
    luc_d = luc_q;
    if (mem_busy) begin
      luc_d = luc_q;
    end else if (lu_hit_s && (luc_q == '0)) begin
      luc_d = LUC_LOAD;
    end else if (luc_q != '0) begin
      luc_d = luc_q - LUC_W'(1);
    end else begin
      luc_d = luc_q;
    end
  end

  always_comb begin
    state_d = state_q;
    dc_d    = dc_q;
    case (state_q)
      ST_RUN: begin
        if (halt_req && !dstall_s && !mem_busy) begin
          state_d = ST_DRAIN;
          dc_d    = DC_LOAD;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (mem_busy) begin
          state_d = ST_DRAIN;
        end else if (dc_q == '0) begin
          state_d = ST_DONE;
        end else begin
          dc_d = dc_q - DC_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_RUN;
        dc_d    = '0;
      end
    endcase
  end

  // Priority chain; all controls stay low while reset is held regardless of inputs.
  always_comb begin
    pc_stall = 1'b0;
    fd_stall = 1'b0;
    de_stall = 1'b0;
    em_stall = 1'b0;
    fd_nop   = 1'b0;
    de_nop   = 1'b0;
    mw_nop   = 1'b0;
    if (!rst) begin
      pc_stall = 1'b0;
    end else if (mem_busy) begin
      pc_stall = 1'b1;
      fd_stall = 1'b1;
      de_stall = 1'b1;
      em_stall = 1'b1;
      mw_nop   = 1'b1;
    end else if (state_q == ST_DONE) begin
      pc_stall = 1'b1;
      fd_stall = 1'b1;
      de_stall = 1'b1;
      em_stall = 1'b1;
    end else if (state_q == ST_DRAIN) begin
      pc_stall = 1'b1;
      fd_stall = 1'b1;
      de_nop   = 1'b1;
    end else if (dstall_s) begin
      pc_stall = 1'b1;
      fd_stall = 1'b1;
      de_nop   = 1'b1;
    end else if (br_taken_s) begin
      fd_nop = 1'b1;
    end else begin
      pc_stall = 1'b0;
    end
  end

  always_comb begin
    if (pc_stall && (state_q != ST_DONE) && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
    halt_done_d = (state_d == ST_DONE);
  end

  // State, counters and the sticky done flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      luc_q       <= '0;
      dc_q        <= '0;
      cnt_q       <= '0;
      halt_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      luc_q       <= luc_d;
      dc_q        <= dc_d;
      cnt_q       <= cnt_d;
      halt_done_q <= halt_done_d;
    end
  end

  assign stall_cnt = cnt_q;
  assign halt_done = halt_done_q;

endmodule

// File: tb/tb_hazard_ctrl_p.sv
// Bench for hazard_ctrl_p: two instances (LOAD_LAT=1/FWD=1/CNT_W=16 and
// LOAD_LAT=3/FWD=0/CNT_W=2) share stimulus; expectations go through a scoreboard.
module tb_hazard_ctrl_p;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] pc_src;
  logic       halt_req;
  logic [5:0] id_src;
  logic [1:0] id_src_vld;
  logic       ex_mem_read, ex_reg_write, mem_reg_write, wb_reg_write, mem_busy;
  logic [2:0] ex_rd, mem_rd, wb_rd;

  logic a_pc, a_fd, a_de, a_em, a_fdn, a_den, a_mwn, a_done;
  logic b_pc, b_fd, b_de, b_em, b_fdn, b_den, b_mwn, b_done;
  logic [15:0] a_cnt;
  logic [1:0]  b_cnt;

  hazard_ctrl_p #(.REG_W(3), .NUM_SRC(2), .PCSRC_W(3), .LOAD_LAT(1), .FWD(1),
                  .DRAIN_CYC(3), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst(rst), .pc_src(pc_src), .halt_req(halt_req), .id_src(id_src),
    .id_src_vld(id_src_vld), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
    .ex_rd(ex_rd), .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_busy(mem_busy),
    .pc_stall(a_pc), .fd_stall(a_fd), .de_stall(a_de), .em_stall(a_em),
    .fd_nop(a_fdn), .de_nop(a_den), .mw_nop(a_mwn), .halt_done(a_done), .stall_cnt(a_cnt));

  hazard_ctrl_p #(.REG_W(3), .NUM_SRC(2), .PCSRC_W(3), .LOAD_LAT(3), .FWD(0),
                  .DRAIN_CYC(3), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .pc_src(pc_src), .halt_req(halt_req), .id_src(id_src),
    .id_src_vld(id_src_vld), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
    .ex_rd(ex_rd), .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_busy(mem_busy),
    .pc_stall(b_pc), .fd_stall(b_fd), .de_stall(b_de), .em_stall(b_em),
    .fd_nop(b_fdn), .de_nop(b_den), .mw_nop(b_mwn), .halt_done(b_done), .stall_cnt(b_cnt));

  // ctl = {halt_done, pc_stall, fd_stall, de_stall, em_stall, fd_nop, de_nop, mw_nop}
  localparam logic [7:0] X_IDLE  = 8'b0000_0000;
  localparam logic [7:0] X_STALL = 8'b0110_0010;
  localparam logic [7:0] X_FLUSH = 8'b0000_0100;
  localparam logic [7:0] X_BUSY  = 8'b0111_1001;
  localparam logic [7:0] X_DONE  = 8'b1111_1000;
  localparam logic [7:0] X_DONEB = 8'b1111_1001;

  typedef struct {
    string       tag;
    int          inst;
    logic [7:0]  ctl;
    logic [15:0] cnt;
  } sb_t;

  sb_t         sb[$];
  sb_t         it;
  logic [23:0] obs;
  logic [15:0] m_cnt [2];
  int          n_chk = 0;
  int          n_err = 0;

  function automatic logic [23:0] observe(input int inst);
    if (inst == 0) return {a_done, a_pc, a_fd, a_de, a_em, a_fdn, a_den, a_mwn, a_cnt};
    else           return {b_done, b_pc, b_fd, b_de, b_em, b_fdn, b_den, b_mwn, 14'd0, b_cnt};
  endfunction

  function automatic logic [15:0] cnt_max(input int inst);
    return (inst == 0) ? 16'hFFFF : 16'd3;
  endfunction

  task automatic push2(input string tag, input int c, input logic [7:0] e0, input logic [7:0] e1);
    sb_t s;
    s.tag = $sformatf("%s_c%0d", tag, c); s.inst = 0; s.ctl = e0; s.cnt = m_cnt[0];
    sb.push_back(s);
    s.inst = 1; s.ctl = e1; s.cnt = m_cnt[1];
    sb.push_back(s);
  endtask

  task automatic drive(input logic [2:0] pcs, input logic hlt, input logic [2:0] s0,
                       input logic [2:0] s1, input logic [1:0] vld, input logic exr,
                       input logic exw, input logic [2:0] exrd, input logic mw,
                       input logic [2:0] mrd, input logic ww, input logic [2:0] wrd,
                       input logic bsy);
    pc_src = pcs; halt_req = hlt; id_src = {s1, s0}; id_src_vld = vld;
    ex_mem_read = exr; ex_reg_write = exw; ex_rd = exrd;
    mem_reg_write = mw; mem_rd = mrd; wb_reg_write = ww; wb_rd = wrd; mem_busy = bsy;
  endtask

  task automatic idle();
    drive(3'd0, 1'b0, 3'd0, 3'd0, 2'b00, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      if (c == 0) begin
        rst = 1'b0;
        drive(3'b010, 1'b1, 3'd3, 3'd0, 2'b01, 1'b1, 1'b1, 3'd3, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
      end else begin
        rst = 1'b1;
        idle();
      end
      push2("reset", c, X_IDLE, X_IDLE);
      @(negedge clk);
      while (sb.size() != 0) begin
        it = sb.pop_front(); obs = observe(it.inst); n_chk++;
        if (obs !== {it.ctl, it.cnt}) begin
          n_err++;
          $display("FAIL %s inst%0d: got ctl=%b cnt=%0d, want ctl=%b cnt=%0d",
                   it.tag, it.inst, obs[23:16], obs[15:0], it.ctl, it.cnt);
        end
        if (it.ctl[6] && !it.ctl[7] && m_cnt[it.inst] != cnt_max(it.inst)) m_cnt[it.inst]++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    for (int c = 0; c < 10; c++) begin
      case (c)
        0, 4: begin
          drive(3'd0, 1'b0, 3'd3, 3'd0, 2'b01, 1'b1, 1'b1, 3'd3, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
          push2("load_use", c, X_STALL, X_STALL);
        end
        1, 2: begin
          drive(3'd0, 1'b0, 3'd3, 3'd0, 2'b01, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
          push2("load_use", c, X_IDLE, X_STALL);
        end
        5, 6: begin
          drive(3'd0, 1'b0, 3'd0, 3'd0, 2'b00, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
          push2("load_use_busy", c, X_BUSY, X_BUSY);
        end
        7, 8: begin
          idle();
          push2("load_use", c, X_IDLE, X_STALL);
        end
        default: begin
          idle();
          push2("load_use", c, X_IDLE, X_IDLE);
        end
      endcase
      @(negedge clk);
      while (sb.size() != 0) begin
        it = sb.pop_front(); obs = observe(it.inst); n_chk++;
        if (obs !== {it.ctl, it.cnt}) begin
          n_err++;
          $display("FAIL %s inst%0d: got ctl=%b cnt=%0d, want ctl=%b cnt=%0d",
                   it.tag, it.inst, obs[23:16], obs[15:0], it.ctl, it.cnt);
        end
        if (it.ctl[6] && !it.ctl[7] && m_cnt[it.inst] != cnt_max(it.inst)) m_cnt[it.inst]++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_raw();
    for (int c = 0; c < 5; c++) begin
      case (c)
        0: begin
          drive(3'd0, 1'b0, 3'd0, 3'd5, 2'b10, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd5, 1'b0);
          push2("raw_wb", c, X_IDLE, X_STALL);
        end
        1: begin
          drive(3'd0, 1'b0, 3'd0, 3'd0, 2'b10, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd0, 1'b0);
          push2("raw_rd0", c, X_IDLE, X_IDLE);
        end
        2: begin
          drive(3'd0, 1'b0, 3'd0, 3'd5, 2'b00, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd5, 1'b0);
          push2("raw_novld", c, X_IDLE, X_IDLE);
        end
        3: begin
          drive(3'd0, 1'b0, 3'd6, 3'd0, 2'b01, 1'b0, 1'b0, 3'd0, 1'b1, 3'd6, 1'b0, 3'd0, 1'b0);
          push2("raw_mem", c, X_IDLE, X_STALL);
        end
        default: begin
          drive(3'd0, 1'b0, 3'd0, 3'd2, 2'b10, 1'b0, 1'b1, 3'd2, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
          push2("raw_ex", c, X_IDLE, X_STALL);
        end
      endcase
      @(negedge clk);
      while (sb.size() != 0) begin
        it = sb.pop_front(); obs = observe(it.inst); n_chk++;
        if (obs !== {it.ctl, it.cnt}) begin
          n_err++;
          $display("FAIL %s inst%0d: got ctl=%b cnt=%0d, want ctl=%b cnt=%0d",
                   it.tag, it.inst, obs[23:16], obs[15:0], it.ctl, it.cnt);
        end
        if (it.ctl[6] && !it.ctl[7] && m_cnt[it.inst] != cnt_max(it.inst)) m_cnt[it.inst]++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    for (int c = 0; c < 7; c++) begin
      case (c)
        0: begin
          drive(3'b010, 1'b0, 3'd0, 3'd0, 2'b00, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
          push2("branch", c, X_FLUSH, X_FLUSH);
        end
        1: begin
          drive(3'b001, 1'b0, 3'd0, 3'd0, 2'b00, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
          push2("branch_seq", c, X_IDLE, X_IDLE);
        end
        2: begin
          drive(3'b010, 1'b0, 3'd3, 3'd0, 2'b01, 1'b1, 1'b1, 3'd3, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
          push2("branch_lu", c, X_STALL, X_STALL);
        end
        3, 4: begin
          drive(3'b010, 1'b0, 3'd3, 3'd0, 2'b01, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
          push2("branch_wait", c, X_FLUSH, X_STALL);
        end
        5: begin
          drive(3'b100, 1'b0, 3'd0, 3'd0, 2'b00, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
          push2("branch_msb", c, X_FLUSH, X_FLUSH);
        end
        default: begin
          idle();
          push2("branch", c, X_IDLE, X_IDLE);
        end
      endcase
      @(negedge clk);
      while (sb.size() != 0) begin
        it = sb.pop_front(); obs = observe(it.inst); n_chk++;
        if (obs !== {it.ctl, it.cnt}) begin
          n_err++;
          $display("FAIL %s inst%0d: got ctl=%b cnt=%0d, want ctl=%b cnt=%0d",
                   it.tag, it.inst, obs[23:16], obs[15:0], it.ctl, it.cnt);
        end
        if (it.ctl[6] && !it.ctl[7] && m_cnt[it.inst] != cnt_max(it.inst)) m_cnt[it.inst]++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_drain_reset();
    for (int c = 0; c < 6; c++) begin
      case (c)
        0: begin
          idle(); halt_req = 1'b1;
          push2("drain_acc", c, X_IDLE, X_IDLE);
        end
        1, 2: begin
          idle(); halt_req = 1'b1;
          push2("drain", c, X_STALL, X_STALL);
        end
        3: begin
          idle(); halt_req = 1'b1; mem_busy = 1'b1;
          push2("drain_busy", c, X_BUSY, X_BUSY);
        end
        4: begin
          rst = 1'b0; idle(); halt_req = 1'b1; mem_busy = 1'b1;
          m_cnt[0] = 16'd0; m_cnt[1] = 16'd0;
          push2("drain_rst", c, X_IDLE, X_IDLE);
        end
        default: begin
          rst = 1'b1; idle();
          push2("drain_rel", c, X_IDLE, X_IDLE);
        end
      endcase
      @(negedge clk);
      while (sb.size() != 0) begin
        it = sb.pop_front(); obs = observe(it.inst); n_chk++;
        if (obs !== {it.ctl, it.cnt}) begin
          n_err++;
          $display("FAIL %s inst%0d: got ctl=%b cnt=%0d, want ctl=%b cnt=%0d",
                   it.tag, it.inst, obs[23:16], obs[15:0], it.ctl, it.cnt);
        end
        if (it.ctl[6] && !it.ctl[7] && m_cnt[it.inst] != cnt_max(it.inst)) m_cnt[it.inst]++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_halt();
    for (int c = 0; c < 11; c++) begin
      case (c)
        0: begin
          drive(3'd0, 1'b1, 3'd3, 3'd0, 2'b01, 1'b1, 1'b1, 3'd3, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
          push2("halt_lu", c, X_STALL, X_STALL);
        end
        1: begin idle(); halt_req = 1'b1; push2("halt", c, X_IDLE, X_STALL); end
        2: begin idle(); halt_req = 1'b1; push2("halt", c, X_STALL, X_STALL); end
        3: begin
          idle(); halt_req = 1'b1; pc_src = 3'b010;
          push2("halt_br", c, X_STALL, X_FLUSH);
        end
        4: begin idle(); mem_busy = 1'b1; push2("halt_busy", c, X_BUSY, X_BUSY); end
        5: begin idle(); push2("halt", c, X_STALL, X_STALL); end
        6, 7: begin idle(); push2("halt_done", c, X_DONE, X_STALL); end
        8: begin idle(); push2("halt_done", c, X_DONE, X_DONE); end
        9: begin idle(); mem_busy = 1'b1; push2("done_busy", c, X_DONEB, X_DONEB); end
        default: begin
          drive(3'b010, 1'b0, 3'd3, 3'd0, 2'b01, 1'b1, 1'b1, 3'd3, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
          push2("done_sticky", c, X_DONE, X_DONE);
        end
      endcase
      @(negedge clk);
      while (sb.size() != 0) begin
        it = sb.pop_front(); obs = observe(it.inst); n_chk++;
        if (obs !== {it.ctl, it.cnt}) begin
          n_err++;
          $display("FAIL %s inst%0d: got ctl=%b cnt=%0d, want ctl=%b cnt=%0d",
                   it.tag, it.inst, obs[23:16], obs[15:0], it.ctl, it.cnt);
        end
        if (it.ctl[6] && !it.ctl[7] && m_cnt[it.inst] != cnt_max(it.inst)) m_cnt[it.inst]++;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_cnt[0] = 16'd0;
    m_cnt[1] = 16'd0;
    rst = 1'b0;
    idle();
    @(posedge clk); #1;
    test_reset();
    test_load_use();
    test_raw();
    test_branch();
    test_drain_reset();
    test_halt();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_p.md
# hazard_ctrl_p

Parametrised pipeline hazard controller for the five-stage core; successor to the fixed 2-source hazard unit. It sits beside the ID stage, watches register IDs and write-enables in ID/EX/MEM/WB, and drives stall (hold) and NOP (bubble/flush) controls to the PC and the four pipeline registers. Beyond single-bubble load-use and branch flush, it adds:
- multi-cycle load latency;
- an optional no-forwarding mode;
- data-memory-busy freeze;
- a halt/createdump drain state machine;
- a saturating stall-cycle counter.

## Interface
Parameters:
- REG_W, 3, register ID width
- NUM_SRC, 2, source operands checked per ID instruction
- PCSRC_W, 3, width of pc_src
- LOAD_LAT, 1, load-use stall cycles (>=1)
- FWD, 1, 1 = full forwarding exists (stall on load-use only); 0 = stall on any RAW
- DRAIN_CYC, 3, cycles for halt instruction to leave EX/MEM/WB (>=1)
- CNT_W, 16, stall counter width

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous active-low reset
- pc_src  in  PCSRC_W  next-PC select from ID; br_taken = |pc_src[PCSRC_W-1:1]
- halt_req  in  1  ID holds halt/createdump
- id_src  in  NUM_SRC*REG_W  ID source register IDs, operand i at [i*REG_W +: REG_W]
- id_src_vld  in  NUM_SRC  operand i actually read
- ex_mem_read, ex_reg_write  in  1 each  ID/EX control
- ex_rd  in  REG_W  ID/EX destination
- mem_reg_write, wb_reg_write  in  1 each  EX/MEM, MEM/WB write-enable
- mem_rd, wb_rd  in  REG_W each  EX/MEM, MEM/WB destination
- mem_busy  in  1  data memory not ready this cycle
- pc_stall, fd_stall, de_stall, em_stall  out  1 each  hold PC / IF-ID / ID-EX / EX-MEM
- fd_nop, de_nop, mw_nop  out  1 each  load bubble into IF-ID / ID-EX / MEM-WB
- halt_done  out  1  pipeline drained after halt (sticky)
- stall_cnt  out  CNT_W  saturating count of stalled cycles

## Operation
Hazard match rules:
- match(rd) = OR over i of (id_src_vld[i] & id_src[i]==rd & rd!=0).
- lu_hit = ex_mem_read & ex_reg_write & match(ex_rd).
- raw_hit = 0 when FWD=1. When FWD=0: (ex_reg_write & match(ex_rd)) | (mem_reg_write & match(mem_rd)) | (wb_reg_write & match(wb_rd)).

Load-use counter luc (width clog2(LOAD_LAT+1)):
- If lu_hit & luc==0 & !mem_busy, load LOAD_LAT-1.
- Else if luc!=0 & !mem_busy, decrement.
- Hold during mem_busy.
- dstall = lu_hit | luc!=0 | raw_hit.

State machine {RUN, DRAIN, DONE}, drain counter dc:
- RUN -> DRAIN when halt_req & !dstall & !mem_busy. Load dc = DRAIN_CYC-1.
- DRAIN: decrement dc when !mem_busy. When dc==0 & !mem_busy -> DONE.
- DONE: absorbing until reset. halt_done=1.

Output priority, highest first:
1. mem_busy (any state): pc/fd/de/em_stall=1, mw_nop=1, all other NOPs 0.
2. DONE: pc/fd/de/em_stall=1, no NOPs.
3. DRAIN: pc_stall=fd_stall=1, de_nop=1. br_taken ignored.
4. RUN & dstall: pc_stall=fd_stall=1, de_nop=1, fd_nop=0 (branch in ID waits for operands).
5. RUN & br_taken: fd_nop=1.
6. Otherwise all outputs 0.

Stall counter:
- stall_cnt increments when pc_stall=1 and state != DONE.
- Saturates at all-ones.

## Timing
- Reset (rst=0, async): state RUN, luc=0, dc=0, stall_cnt=0, halt_done=0.
- With reset asserted, all stall/NOP outputs read 0 since inputs are don't-care. Release takes effect at the next clk edge.
- Stall/NOP outputs are combinational from inputs + state, valid the same cycle. halt_done and stall_cnt are registered.
- Load-use stall length = LOAD_LAT cycles plus every mem_busy cycle overlapping it. LOAD_LAT=1 gives the classic single bubble.
- Halt: halt_done rises DRAIN_CYC+1 edges after the accepting edge (cycle with halt_req accepted counts as cycle 0), plus any mem_busy cycles.
- Simultaneous lu_hit and halt_req: halt not accepted until dstall clears.
- Simultaneous dstall and br_taken: stall wins; flush happens in the cycle dstall drops.
- Reset mid-DRAIN or mid-luc: immediate return to RUN, counters cleared.
- rd==0 never matches. id_src_vld=0 operands never match.

## Test plan
- LOAD_LAT=1: ex_mem_read=1, ex_reg_write=1, ex_rd=3, id_src[0]=3 valid -> one cycle pc_stall=fd_stall=de_nop=1, then 0. stall_cnt=1.
- LOAD_LAT=3: same hit, ex_rd/ID changes after first edge -> stall exactly 3 cycles. mem_busy pulsed 2 cycles mid-stall -> 5 cycles total. mw_nop=1 only in busy cycles.
- FWD=0: wb_reg_write=1, wb_rd=5, id_src[1]=5 valid -> de_nop=1. Same with wb_rd=0 or id_src_vld[1]=0 -> no stall.
- pc_src=3'b010 with no hazard -> fd_nop=1 only. Same with concurrent lu_hit -> fd_nop=0, de_nop=1.
- DRAIN_CYC=3: halt_req for 1 cycle -> pc_stall=1 held. halt_done=1 at 4th edge, all stalls=1 after. stall_cnt stops.
- Assert rst=0 in DRAIN with stall_cnt=7 -> halt_done=0, stall_cnt=0, all outputs 0 immediately. Saturation: CNT_W=2, 5 stall cycles -> stall_cnt=3.
